// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: select encoding, shadow pipeline tag,
// and the writer-match / select helpers used by the EX-stage comparators.
package hazard_pkg;

   localparam int unsigned REG_ADDR_BITS = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_IMM = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic                     valid;
      logic [REG_ADDR_BITS-1:0] rd;
      logic                     reg_write;
      logic                     mem_read;
      logic                     uses_rs1;
      logic                     uses_rs2;
      logic                     alu_src_imm;
      logic [REG_ADDR_BITS-1:0] rs1;
      logic [REG_ADDR_BITS-1:0] rs2;
   } pipe_tag_t;

   localparam pipe_tag_t BUBBLE_TAG = '0;

   // x0 is hardwired to zero, so a write to it never produces a forwardable value
   function automatic logic writer_match(
      input logic                     valid,
      input logic                     reg_write,
      input logic [REG_ADDR_BITS-1:0] rd,
      input logic [REG_ADDR_BITS-1:0] src
   );
      return valid && reg_write && (rd != '0) && (rd == src);
   endfunction

   // MEM holds the newer writer, so it takes priority over WB
   function automatic fwd_sel_e fwd_select(
      input logic uses,
      input logic mem_hit,
      input logic wb_hit
   );
      if (!uses)        return FWD_REG;
      else if (mem_hit) return FWD_MEM;
      else if (wb_hit)  return FWD_WB;
      else              return FWD_REG;
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID-stage decode fields in, mux selects and stall out.
// Optional HAZARD_STATS_EN adds the stall/forward counter outputs.
interface forwarding_hazard_unit_if #(
   parameter int unsigned data_bits     = 32,
   parameter int unsigned reg_addr_bits = 5
);

   logic                     id_valid;
   logic [reg_addr_bits-1:0] id_rs1;
   logic [reg_addr_bits-1:0] id_rs2;
   logic [reg_addr_bits-1:0] id_rd;
   logic                     id_uses_rs1;
   logic                     id_uses_rs2;
   logic                     id_alu_src_imm;
   logic                     id_reg_write;
   logic                     id_mem_read;
   logic                     ex_flush;
   logic                     pipe_hold;

   logic [1:0]               forward_controller_1;
   logic [1:0]               forward_controller_2;
   logic [1:0]               store_data_forward;
   logic                     stall_if_id;
   logic                     bubble_id_ex;

`ifdef HAZARD_STATS_EN
   logic [data_bits-1:0]     stall_count;
   logic [data_bits-1:0]     forward_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_alu_src_imm, id_reg_write, id_mem_read, ex_flush, pipe_hold,
      input  forward_controller_1, forward_controller_2, store_data_forward,
             stall_if_id, bubble_id_ex, stall_count, forward_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_alu_src_imm, id_reg_write, id_mem_read, ex_flush, pipe_hold,
      output forward_controller_1, forward_controller_2, store_data_forward,
             stall_if_id, bubble_id_ex, stall_count, forward_count
   );
`else
   logic [data_bits-1:0]     unused_stats_w;
   assign unused_stats_w = '0;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_alu_src_imm, id_reg_write, id_mem_read, ex_flush, pipe_hold,
      input  forward_controller_1, forward_controller_2, store_data_forward,
             stall_if_id, bubble_id_ex
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_alu_src_imm, id_reg_write, id_mem_read, ex_flush, pipe_hold,
      output forward_controller_1, forward_controller_2, store_data_forward,
             stall_if_id, bubble_id_ex
   );
`endif

endinterface

// File: rtl/forwarding_hazard_unit_tag_stage.sv
// One shadow-pipeline tag register: hold freezes it, bubble loads an empty tag.
module hazard_tag_stage
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      hold_i,
   input  logic      bubble_i,
   input  pipe_tag_t tag_i,
   output pipe_tag_t tag_o
);

   pipe_tag_t tag_d;
   pipe_tag_t tag_q;

   always_comb begin
      tag_d = tag_q;
      if (!hold_i) begin
         tag_d = bubble_i ? BUBBLE_TAG : tag_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) tag_q <= BUBBLE_TAG;
      else     tag_q <= tag_d;
   end

   assign tag_o = tag_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX operand-forwarding selects and load-use stall for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall_count / forward_count outputs.
module forwarding_hazard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned data_bits     = 32,
   parameter int unsigned reg_addr_bits = 5
)(
   input logic                     clk,
   input logic                     rst,
   forwarding_hazard_unit_if.slave hz
);

   pipe_tag_t id_tag;
   pipe_tag_t ex_tag;
   pipe_tag_t mem_tag;
   pipe_tag_t wb_tag;

   logic      stall;
   logic      ex_bubble;

   logic [reg_addr_bits-1:0] ex_rd;

   logic      mem_hit1, mem_hit2, wb_hit1, wb_hit2;
   fwd_sel_e  fc1_sel, fc2_sel, sdf_sel;

   always_comb begin
      id_tag             = BUBBLE_TAG;
      id_tag.valid       = hz.id_valid;
      id_tag.rd          = hz.id_rd;
      id_tag.reg_write   = hz.id_reg_write;
      id_tag.mem_read    = hz.id_mem_read;
      id_tag.uses_rs1    = hz.id_uses_rs1;
      id_tag.uses_rs2    = hz.id_uses_rs2;
      id_tag.alu_src_imm = hz.id_alu_src_imm;
      id_tag.rs1         = hz.id_rs1;
      id_tag.rs2         = hz.id_rs2;
   end

   assign ex_rd = ex_tag.rd;

   // Flush and hold both override the load-use stall
   always_comb begin
      stall = hz.id_valid && ex_tag.valid && ex_tag.mem_read && (ex_rd != '0) &&
              ((hz.id_uses_rs1 && (hz.id_rs1 == ex_rd)) ||
               (hz.id_uses_rs2 && (hz.id_rs2 == ex_rd)));
      if (hz.ex_flush || hz.pipe_hold) stall = 1'b0;
   end

   // Non-valid ID slots enter EX as an empty tag so a bubble never forwards
   assign ex_bubble = hz.ex_flush || stall || !hz.id_valid;

   hazard_tag_stage u_ex_stage (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (hz.pipe_hold),
      .bubble_i (ex_bubble),
      .tag_i    (id_tag),
      .tag_o    (ex_tag)
   );

   hazard_tag_stage u_mem_stage (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (hz.pipe_hold),
      .bubble_i (1'b0),
      .tag_i    (ex_tag),
      .tag_o    (mem_tag)
   );

   hazard_tag_stage u_wb_stage (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (hz.pipe_hold),
      .bubble_i (1'b0),
      .tag_i    (mem_tag),
      .tag_o    (wb_tag)
   );

   always_comb begin
      mem_hit1 = writer_match(mem_tag.valid, mem_tag.reg_write, mem_tag.rd, ex_tag.rs1);
      mem_hit2 = writer_match(mem_tag.valid, mem_tag.reg_write, mem_tag.rd, ex_tag.rs2);
      wb_hit1  = writer_match(wb_tag.valid,  wb_tag.reg_write,  wb_tag.rd,  ex_tag.rs1);
      wb_hit2  = writer_match(wb_tag.valid,  wb_tag.reg_write,  wb_tag.rd,  ex_tag.rs2);

      fc1_sel  = fwd_select(ex_tag.uses_rs1, mem_hit1, wb_hit1);
      sdf_sel  = fwd_select(ex_tag.uses_rs2, mem_hit2, wb_hit2);
      fc2_sel  = ex_tag.alu_src_imm ? FWD_IMM : sdf_sel;
   end

   assign hz.forward_controller_1 = fc1_sel;
   assign hz.forward_controller_2 = fc2_sel;
   assign hz.store_data_forward   = sdf_sel;
   assign hz.stall_if_id          = stall;
   assign hz.bubble_id_ex         = stall;

   logic unused_tag_bits;
   assign unused_tag_bits = ^{mem_tag, wb_tag, hz.id_valid};

`ifdef HAZARD_STATS_EN
   logic [data_bits-1:0] stall_cnt_d, stall_cnt_q;
   logic [data_bits-1:0] fwd_cnt_d,   fwd_cnt_q;
   logic                 fwd_any;

   always_comb begin
      fwd_any = (fc1_sel == FWD_WB) || (fc1_sel == FWD_MEM) ||
                (fc2_sel == FWD_WB) || (fc2_sel == FWD_MEM) ||
                (sdf_sel == FWD_WB) || (sdf_sel == FWD_MEM);
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (!hz.pipe_hold) begin
         if (stall   && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
         if (fwd_any && (fwd_cnt_q   != '1)) fwd_cnt_d   = fwd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign hz.stall_count   = stall_cnt_q;
   assign hz.forward_count = fwd_cnt_q;
`else
   logic [data_bits-1:0] unused_stats;
   assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed-vector bench for forwarding_hazard_unit; obs packs {fc1, fc2, sdf, stall, bubble}.
module tb_forwarding_hazard_unit;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   forwarding_hazard_unit_if #(.data_bits(32), .reg_addr_bits(5)) hz ();

   forwarding_hazard_unit #(.data_bits(32), .reg_addr_bits(5)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   logic [7:0] obs;
   assign obs = {hz.forward_controller_1, hz.forward_controller_2,
                 hz.store_data_forward, hz.stall_if_id, hz.bubble_id_ex};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic imm, input logic rw, input logic mr);
      hz.id_valid       = v;
      hz.id_rs1         = rs1;
      hz.id_rs2         = rs2;
      hz.id_rd          = rd;
      hz.id_uses_rs1    = u1;
      hz.id_uses_rs2    = u2;
      hz.id_alu_src_imm = imm;
      hz.id_reg_write   = rw;
      hz.id_mem_read    = mr;
      #1;
   endtask

   task automatic set_idle();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      hz.ex_flush  = 1'b0;
      hz.pipe_hold = 1'b0;
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 8'b00000000);
      end
      // a reader in ID against an empty EX never stalls
      set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL reset_id_reader got=%b exp=%b", obs, 8'b00000000);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (hz.stall_count !== 32'd0 || hz.forward_count !== 32'd0) begin
         failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hz.stall_count, hz.forward_count);
      end
`endif
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // add x5,x1,x2
      tick();
      set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // sub x6,x5,x7
      checks++;
      if (hz.stall_if_id !== 1'b0) begin
         failures++; $display("FAIL b2b_no_stall got=%b exp=0", hz.stall_if_id);
      end
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b10_00_00_0_0) begin
         failures++; $display("FAIL b2b_sub_ex got=%b exp=%b", obs, 8'b10000000);
      end
   endtask

   task automatic test_wb_forward();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x5
      tick();
      set_id(1'b1, 5'd12, 5'd13, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // add x11
      tick();
      set_id(1'b1, 5'd1, 5'd5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // or x8,x1,x5
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b00_01_01_0_0) begin
         failures++; $display("FAIL wb_or_ex got=%b exp=%b", obs, 8'b00010100);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // lw x5,0(x1)
      tick();
      set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x6,x5,x5
      checks++;
      if (obs !== 8'b00_11_00_1_1) begin
         failures++; $display("FAIL lu_stall got=%b exp=%b", obs, 8'b00110011);
      end
      tick();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL lu_bubble_ex got=%b exp=%b", obs, 8'b00000000);
      end
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b01_01_01_0_0) begin
         failures++; $display("FAIL lu_add_ex got=%b exp=%b", obs, 8'b01010100);
      end
   endtask

   task automatic test_x0();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x0,x1,x2
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x3,x0,x0
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL x0_no_fwd got=%b exp=%b", obs, 8'b00000000);
      end
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // lw x0
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (hz.stall_if_id !== 1'b0) begin
         failures++; $display("FAIL x0_load_no_stall got=%b exp=0", hz.stall_if_id);
      end
      set_idle();
   endtask

   task automatic test_priority();
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x9
      tick();
      set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x9
      tick();
      set_id(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);  // addi x10,x9,4
      tick();
      set_id(1'b1, 5'd2, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // sw x9,0(x2)
      checks++;
      if (obs !== 8'b10_11_00_0_0) begin
         failures++; $display("FAIL prio_addi_ex got=%b exp=%b", obs, 8'b10110000);
      end
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b00_11_01_0_0) begin
         failures++; $display("FAIL store_data_wb got=%b exp=%b", obs, 8'b00110100);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // lw x5
      tick();
      hz.ex_flush = 1'b1;
      set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x5,x5,x5 (killed)
      checks++;
      if (hz.stall_if_id !== 1'b0 || hz.bubble_id_ex !== 1'b0) begin
         failures++; $display("FAIL flush_no_stall got=%b%b exp=00", hz.stall_if_id, hz.bubble_id_ex);
      end
      tick();
      hz.ex_flush = 1'b0;
      set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // or x8,x5,x5
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL flush_ex_bubble got=%b exp=%b", obs, 8'b00000000);
      end
      tick();
      set_idle();
      // killed add would have forwarded from MEM (10) if it had entered EX
      checks++;
      if (obs !== 8'b01_01_01_0_0) begin
         failures++; $display("FAIL flush_or_ex got=%b exp=%b", obs, 8'b01010100);
      end
   endtask

   task automatic test_hold();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // lw x5
      tick();
      hz.pipe_hold = 1'b1;
      set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);   // add x6,x5,x0
      checks++;
      if (obs !== 8'b00_11_00_0_0) begin
         failures++; $display("FAIL hold_enter got=%b exp=%b", obs, 8'b00110000);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== 8'b00_11_00_0_0) begin
            failures++; $display("FAIL hold_cycle%0d got=%b exp=%b", i, obs, 8'b00110000);
         end
`ifdef HAZARD_STATS_EN
         checks++;
         if (hz.stall_count !== 32'd0 || hz.forward_count !== 32'd0) begin
            failures++; $display("FAIL hold_counters got=%0d/%0d exp=0/0", hz.stall_count, hz.forward_count);
         end
`endif
      end
      hz.pipe_hold = 1'b0;
      #1;
      checks++;
      if (obs !== 8'b00_11_00_1_1) begin
         failures++; $display("FAIL hold_release_stall got=%b exp=%b", obs, 8'b00110011);
      end
      tick();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL hold_bubble got=%b exp=%b", obs, 8'b00000000);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (hz.stall_count !== 32'd1) begin
         failures++; $display("FAIL stall_count got=%0d exp=1", hz.stall_count);
      end
`endif
      tick();
      set_idle();
      checks++;
      if (obs !== 8'b01_00_00_0_0) begin
         failures++; $display("FAIL hold_add_ex got=%b exp=%b", obs, 8'b01000000);
      end
      tick();
`ifdef HAZARD_STATS_EN
      checks++;
      if (hz.forward_count !== 32'd1 || hz.stall_count !== 32'd1) begin
         failures++; $display("FAIL forward_count got=%0d/%0d exp=1/1", hz.forward_count, hz.stall_count);
      end
`endif
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);   // lw x5
      tick();
      set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (hz.stall_if_id !== 1'b1) begin
         failures++; $display("FAIL mid_stall_pre got=%b exp=1", hz.stall_if_id);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs !== 8'b00_00_00_0_0) begin
         failures++; $display("FAIL mid_stall_reset got=%b exp=%b", obs, 8'b00000000);
      end
      rst = 1'b0;
      set_idle();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      test_reset();
      test_back_to_back();
      test_wb_forward();
      test_load_use();
      test_x0();
      test_priority();
      test_flush();
      test_hold();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
